// File: rtl/eight_bit_register.sv
// rtl/eight_bit_register.sv - parallel-load data register with asynchronous active-high reset
`timescale 1ns/1ps

module eight_bit_register #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic [WIDTH-1:0] d,
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;

    // No enable: every rising edge outside reset reloads from d.
    always_comb begin
        q_d = d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= RESET_VALUE;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: tb/tb_eight_bit_register.sv
// tb/tb_eight_bit_register.sv - self-checking bench for eight_bit_register
`timescale 1ns/1ps

module tb_eight_bit_register;

    localparam int         W  = 8;
    localparam logic [7:0] RV = 8'h00;

    logic [W-1:0] d;
    logic         clk;
    logic         reset;
    logic [W-1:0] q;

    int  checks = 0;
    int  errors = 0;
    bit  done   = 0;

    // Stimulus history: the model answers "what must q be at time t" from these logs.
    time d_t[$];
    int  d_v[$];
    time r_t[$];
    bit  r_v[$];

    eight_bit_register #(.WIDTH(W), .RESET_VALUE(RV)) dut (
        .d    (d),
        .clk  (clk),
        .reset(reset),
        .q    (q)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got 0x%0h expected 0x%0h", name, $time, got, exp);
        end
    endtask

    task automatic set_d(input int v);
        d = v[W-1:0];
        d_t.push_back($time);
        d_v.push_back(v);
    endtask

    task automatic set_reset(input bit v);
        reset = v;
        r_t.push_back($time);
        r_v.push_back(v);
    endtask

    task automatic wait_until(input time t);
        if (t > $time) #(t - $time);
    endtask

    function automatic int d_at(input time t);
        for (int i = d_t.size() - 1; i >= 0; i--)
            if (d_t[i] <= t) return d_v[i] % (1 << W);
        return 0;
    endfunction

    function automatic bit reset_at(input time t);
        for (int i = r_t.size() - 1; i >= 0; i--)
            if (r_t[i] <= t) return r_v[i];
        return 1'b0;
    endfunction

    function automatic bit reset_seen(input time t0, input time t1);
        if (reset_at(t0)) return 1'b1;
        for (int i = 0; i < r_t.size(); i++)
            if (r_t[i] > t0 && r_t[i] <= t1 && r_v[i]) return 1'b1;
        return 1'b0;
    endfunction

    // q is RESET_VALUE if reset touched the interval since the last rising edge,
    // otherwise it is the d word present at that edge.
    function automatic int model_q(input time t);
        time te;
        if (t < 10) return int'(RV);
        te = 10 + 20 * ((t - 10) / 20);
        if (reset_seen(te, t)) return int'(RV);
        return d_at(te);
    endfunction

    initial begin
        while (!done) begin
            @(posedge clk);
            #5;
            if (!done) check("model_cmp", int'(q), model_q($time));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int vals[8];
        int tf;
        vals = '{0, 65, 32, 241, 73, 16, 25, 69};

        set_reset(1'b1);
        set_d(0);
        #5;
        check("reset_initial", int'(q), 0);

        for (int i = 0; i < 8; i++) begin
            wait_until(20 * i);
            set_d(vals[i]);
            wait_until(20 * i + 13);
            check("reset_hold", int'(q), 0);
        end

        wait_until(160);
        set_reset(1'b0);
        wait_until(165);
        check("pre_release", int'(q), 0);
        wait_until(174);
        check("release_load", int'(q), 8'h45);
        check("model_pin_release", model_q($time), 8'h45);
        wait_until(180);
        set_d(64);
        wait_until(185);
        check("hold_between", int'(q), 8'h45);
        wait_until(194);
        check("load_64", int'(q), 8'h40);
        wait_until(200);
        set_d(123);
        wait_until(214);
        check("load_123", int'(q), 8'h7B);

        wait_until(220);
        set_reset(1'b1);
        set_d(93);
        #1;
        check("async_assert", int'(q), 0);
        check("model_pin_async", model_q($time), 0);
        wait_until(240);
        set_d(256);
        wait_until(260);
        set_d(198);
        wait_until(274);
        check("reset_ignores_edges", int'(q), 0);

        wait_until(280);
        set_reset(1'b0);
        set_d(256);
        wait_until(294);
        check("truncate_256", int'(q), 0);
        wait_until(300);
        set_d(255);
        wait_until(314);
        check("load_ff", int'(q), 8'hFF);

        wait_until(320);
        set_d(8'h11);
        wait_until(323);
        set_d(8'h22);
        wait_until(327);
        set_d(8'h33);
        wait_until(333);
        set_d(8'h44);
        wait_until(334);
        check("toggle_capture", int'(q), 8'h33);
        wait_until(336);
        check("toggle_after_edge", int'(q), 8'h33);
        check("model_pin_toggle", model_q($time), 8'h33);

        for (int k = 0; k < 300; k++) begin
            tf = 340 + 20 * k;
            wait_until(tf);
            if ($urandom_range(7) == 0) set_d(int'($urandom_range(1023, 256)));
            else                        set_d(int'($urandom_range(255)));
            wait_until(tf + 3);
            if ($urandom_range(3) == 0) set_d(int'($urandom_range(511)));
            wait_until(tf + 5);
            if ($urandom_range(9) == 0) begin
                set_reset(~reset);
                if (reset) begin
                    #1;
                    check("async_assert_rand", int'(q), int'(RV));
                end
            end
            wait_until(tf + 16);
            if ($urandom_range(2) == 0) set_d(int'($urandom_range(255)));
        end

        done = 1'b1;
        @(posedge clk);
        #10;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
